// File: rtl/biu_pkg.sv
// Shared types and constants for the minimum-mode bus interface unit.
// Widths are fixed: 20-bit physical address and 16-bit AD bus.
package biu_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5,
        ST_HOLD = 3'd6
    } state_t;

    // Segment status codes driven on S4:S3 from T2 through T4.
    localparam logic [1:0] SEG_ES = 2'b00;
    localparam logic [1:0] SEG_SS = 2'b01;
    localparam logic [1:0] SEG_CS = 2'b10;
    localparam logic [1:0] SEG_DS = 2'b11;

    // BHE# is asserted for word transfers and for byte transfers on the odd (high) lane.
    function automatic logic bhe_n_of(input logic word, input logic addr0);
        return !(word | addr0);
    endfunction

endpackage

// File: rtl/biu_bus_ctrl.sv
// Minimum-mode bus cycle controller: runs T1/T2/T3/TW/T4 cycles on a split AD bus.
// Optional bus hold/acknowledge support is built when macro BIU_HOLD_EN is defined.
module biu_bus_ctrl
    import biu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic        req_word,
    input  logic [19:0] req_addr,
    input  logic [1:0]  req_seg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic [15:0] ad_in,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic [3:0]  a_hi_status,
    output logic        bhe_n,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        m_io,
    output logic        dt_r_n,
    output logic        den_n,
    output logic        bus_oe,
    input  logic        ready,
    input  logic        hold,
    output logic        hlda
);

    state_t      state;
    state_t      state_next;
    logic        enter_hold;
    logic        accept;
    logic        capture_rd;

    logic        lat_write;
    logic        lat_mem;
    logic        lat_word;
    logic [19:0] lat_addr;
    logic [1:0]  lat_seg;
    logic [15:0] lat_wdata;

    // Hold is only honoured at cycle boundaries and beats a simultaneous request.
    always_comb begin
        enter_hold = 1'b0;
`ifdef BIU_HOLD_EN
        enter_hold = hold && ((state == ST_IDLE) || (state == ST_T4));
`endif
    end

`ifndef BIU_HOLD_EN
    logic unused_hold;
    assign unused_hold = hold;
`endif

    assign req_ready  = ((state == ST_IDLE) || (state == ST_T4)) && !enter_hold;
    assign accept     = req_valid && req_ready;
    assign capture_rd = ((state == ST_T3) || (state == ST_TW)) && ready && !lat_write;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_T4: begin
                if (enter_hold) begin
                    state_next = ST_HOLD;
                end else if (req_valid) begin
                    state_next = ST_T1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_T1:        state_next = ST_T2;
            ST_T2:        state_next = ST_T3;
            ST_T3, ST_TW: state_next = ready ? ST_T4 : ST_TW;
            ST_HOLD: begin
`ifdef BIU_HOLD_EN
                state_next = hold ? ST_HOLD : ST_IDLE;
`else
                state_next = ST_IDLE;
`endif
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are only consulted in T1..T4, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_mem   <= req_mem;
            lat_word  <= req_word;
            lat_addr  <= req_addr;
            lat_seg   <= req_seg;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= '0;
        end else if (capture_rd) begin
            rsp_rdata <= ad_in;
        end
    end

    // Bus outputs decode only from the state register and latched request.
    always_comb begin
        ale         = 1'b0;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        den_n       = 1'b1;
        dt_r_n      = 1'b1;
        m_io        = 1'b1;
        ad_oe       = 1'b0;
        ad_out      = '0;
        a_hi_status = '0;
        bhe_n       = 1'b1;
        rsp_valid   = 1'b0;
        hlda        = 1'b0;
        bus_oe      = 1'b1;
        case (state)
            ST_T1: begin
                ale         = 1'b1;
                ad_oe       = 1'b1;
                ad_out      = lat_addr[15:0];
                a_hi_status = lat_addr[19:16];
                bhe_n       = bhe_n_of(lat_word, lat_addr[0]);
                m_io        = lat_mem;
            end
            ST_T2, ST_T3, ST_TW: begin
                a_hi_status = {2'b00, lat_seg};
                bhe_n       = bhe_n_of(lat_word, lat_addr[0]);
                m_io        = lat_mem;
                den_n       = 1'b0;
                if (lat_write) begin
                    ad_oe  = 1'b1;
                    ad_out = lat_wdata;
                    wr_n   = 1'b0;
                    dt_r_n = 1'b1;
                end else begin
                    rd_n   = 1'b0;
                    dt_r_n = 1'b0;
                end
            end
            ST_T4: begin
                a_hi_status = {2'b00, lat_seg};
                bhe_n       = bhe_n_of(lat_word, lat_addr[0]);
                m_io        = lat_mem;
                rsp_valid   = !lat_write;
            end
            ST_HOLD: begin
`ifdef BIU_HOLD_EN
                hlda   = 1'b1;
                bus_oe = 1'b0;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_biu_bus_ctrl.sv
// Randomized self-checking bench for biu_bus_ctrl against a phase-indexed bus-cycle model.
// Exercises the hold path when BIU_HOLD_EN is defined, otherwise checks hold is ignored.
module tb_biu_bus_ctrl;
    import biu_pkg::*;

`ifdef BIU_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_mem;
    logic        req_word;
    logic [19:0] req_addr;
    logic [1:0]  req_seg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic [3:0]  a_hi_status;
    logic        bhe_n;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        m_io;
    logic        dt_r_n;
    logic        den_n;
    logic        bus_oe;
    logic        ready;
    logic        hold;
    logic        hlda;

    biu_bus_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_mem(req_mem), .req_word(req_word),
        .req_addr(req_addr), .req_seg(req_seg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_hi_status(a_hi_status), .bhe_n(bhe_n),
        .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .m_io(m_io),
        .dt_r_n(dt_r_n), .den_n(den_n),
        .bus_oe(bus_oe), .ready(ready), .hold(hold), .hlda(hlda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic        mem;
        logic        word;
        logic [19:0] addr;
        logic [1:0]  seg;
        logic [15:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        req_ready;
        logic        ale;
        logic        rd_n;
        logic        wr_n;
        logic        m_io;
        logic        dt_r_n;
        logic        den_n;
        logic        ad_oe;
        logic [15:0] ad_out;
        logic [3:0]  a_hi;
        logic        bhe_n;
        logic        rsp_valid;
        logic        bus_oe;
        logic        hlda;
    } obs_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    obs_t        trace [0:31];
    int          trace_len;
    logic [15:0] t4_rdata;

    // ad_out is only meaningful while driven.
    function automatic obs_t sample();
        obs_t s;
        s.req_ready = req_ready;
        s.ale       = ale;
        s.rd_n      = rd_n;
        s.wr_n      = wr_n;
        s.m_io      = m_io;
        s.dt_r_n    = dt_r_n;
        s.den_n     = den_n;
        s.ad_oe     = ad_oe;
        s.ad_out    = ad_oe ? ad_out : 16'h0;
        s.a_hi      = a_hi_status;
        s.bhe_n     = bhe_n;
        s.rsp_valid = rsp_valid;
        s.bus_oe    = bus_oe;
        s.hlda      = hlda;
        return s;
    endfunction

    function automatic obs_t idle_exp();
        obs_t o;
        o = '0;
        o.req_ready = 1'b1;
        o.rd_n      = 1'b1;
        o.wr_n      = 1'b1;
        o.m_io      = 1'b1;
        o.dt_r_n    = 1'b1;
        o.den_n     = 1'b1;
        o.bhe_n     = 1'b1;
        o.bus_oe    = 1'b1;
        return o;
    endfunction

    // Phase 0 is T1, 1 is T2, 2..2+nwait are T3 and waits, 3+nwait is T4.
    function automatic obs_t model(input int ph, input int nwait, input txn_t t, input bit hold_on);
        obs_t o;
        bit   data_ph;
        bit   is_t4;
        data_ph     = (ph >= 1) && (ph <= 2 + nwait);
        is_t4       = (ph == 3 + nwait);
        o.req_ready = is_t4 && !(HOLD_EN && hold_on);
        o.ale       = (ph == 0);
        o.rd_n      = !(data_ph && !t.wr);
        o.wr_n      = !(data_ph && t.wr);
        o.m_io      = t.mem;
        o.dt_r_n    = data_ph ? t.wr : 1'b1;
        o.den_n     = !data_ph;
        o.ad_oe     = (ph == 0) || (data_ph && t.wr);
        o.ad_out    = (ph == 0) ? t.addr[15:0] : ((data_ph && t.wr) ? t.wdata : 16'h0);
        o.a_hi      = (ph == 0) ? t.addr[19:16] : {2'b00, t.seg};
        o.bhe_n     = !(t.word || t.addr[0]);
        o.rsp_valid = is_t4 && !t.wr;
        o.bus_oe    = 1'b1;
        o.hlda      = 1'b0;
        return o;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom);
        t.mem   = 1'($urandom);
        t.word  = 1'($urandom);
        t.addr  = 20'($urandom);
        t.seg   = 2'($urandom);
        t.wdata = 16'($urandom);
        return t;
    endfunction

    task automatic present(input txn_t t);
        req_valid = 1'b1;
        req_write = t.wr;
        req_mem   = t.mem;
        req_word  = t.word;
        req_addr  = t.addr;
        req_seg   = t.seg;
        req_wdata = t.wdata;
    endtask

    // Drives one bus cycle from the T1 entry edge through T4 and records outputs per phase.
    task automatic run_xfer(input txn_t t, input int nwait, input logic [15:0] rdata,
                            input bit chain, input txn_t nxt, input bit hold_mid);
        trace_len = 4 + nwait;
        for (int ph = 0; ph < 4 + nwait; ph++) begin
            @(posedge clk);
            #1;
            if (ph == 0) begin
                req_valid = 1'b0;
                req_addr  = 20'($urandom);
                req_wdata = 16'($urandom);
                req_seg   = 2'($urandom);
                req_write = 1'($urandom);
            end
            if (ph == 1 && hold_mid) hold = 1'b1;
            if (ph >= 2 && ph <= 2 + nwait) begin
                ready = (ph == 2 + nwait);
                ad_in = (ph == 2 + nwait) ? rdata : 16'($urandom);
            end else begin
                ready = 1'($urandom);
                ad_in = 16'($urandom);
            end
            if (ph == 3 + nwait && chain) present(nxt);
            @(negedge clk);
            trace[ph] = sample();
            if (ph == 3 + nwait) t4_rdata = rsp_rdata;
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; hold = 1'b0; ready = 1'b1; ad_in = 16'hFFFF;
        req_valid = 1'b0; req_write = 1'b0; req_mem = 1'b0; req_word = 1'b0;
        req_addr = '0; req_seg = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sample() !== idle_exp()) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", sample(), idle_exp());
        end
        n_checks++;
        if (ad_out !== 16'h0 || rsp_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: ad_out %h rsp_rdata %h, expected 0000 0000", ad_out, rsp_rdata);
        end
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_mem_read();
        txn_t t;
        obs_t e;
        int   rd_low;
        t = '{wr: 1'b0, mem: 1'b1, word: 1'b1, addr: 20'h12345, seg: SEG_DS, wdata: 16'h0};
        @(posedge clk); #1; present(t);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mem_read_ready: got %b expected 1", req_ready); end
        run_xfer(t, 0, 16'hBEEF, 1'b0, t, 1'b0);
        rd_low = 0;
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 0, t, 1'b0);
            if (trace[i].rd_n == 1'b0) rd_low++;
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL mem_read ph%0d: got %h expected %h", i, trace[i], e); end
        end
        n_checks++;
        if (trace[0].ad_out !== 16'h2345 || trace[0].a_hi !== 4'h1 || trace[0].ale !== 1'b1) begin
            n_fail++; $display("FAIL mem_read_t1: ad_out %h a_hi %h ale %b, expected 2345 1 1", trace[0].ad_out, trace[0].a_hi, trace[0].ale);
        end
        n_checks++;
        if (rd_low !== 2) begin n_fail++; $display("FAIL mem_read_rd_len: got %0d expected 2", rd_low); end
        n_checks++;
        if (t4_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL mem_read_data: got %h expected beef", t4_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (sample() !== idle_exp()) begin n_fail++; $display("FAIL mem_read_idle: got %h expected %h", sample(), idle_exp()); end
    endtask

    task automatic test_io_write();
        txn_t t;
        obs_t e;
        int   wr_low;
        int   rsp_cnt;
        t = '{wr: 1'b1, mem: 1'b0, word: 1'b0, addr: 20'h00081, seg: SEG_ES, wdata: 16'h5A00};
        @(posedge clk); #1; present(t);
        run_xfer(t, 0, 16'h1234, 1'b0, t, 1'b0);
        wr_low = 0; rsp_cnt = 0;
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 0, t, 1'b0);
            if (trace[i].wr_n == 1'b0) wr_low++;
            if (trace[i].rsp_valid) rsp_cnt++;
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL io_write ph%0d: got %h expected %h", i, trace[i], e); end
        end
        n_checks++;
        if (wr_low !== 2 || rsp_cnt !== 0) begin
            n_fail++; $display("FAIL io_write_strobes: wr low %0d rsp %0d, expected 2 0", wr_low, rsp_cnt);
        end
        n_checks++;
        if (trace[1].ad_out !== 16'h5A00 || trace[1].m_io !== 1'b0 || trace[1].bhe_n !== 1'b0) begin
            n_fail++; $display("FAIL io_write_t2: ad_out %h m_io %b bhe_n %b, expected 5a00 0 0", trace[1].ad_out, trace[1].m_io, trace[1].bhe_n);
        end
    endtask

    task automatic test_wait_states();
        txn_t t;
        obs_t e;
        int   rd_low;
        t = rand_txn();
        t.wr = 1'b0;
        @(posedge clk); #1; present(t);
        run_xfer(t, 3, 16'hC0DE, 1'b0, t, 1'b0);
        rd_low = 0;
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 3, t, 1'b0);
            if (trace[i].rd_n == 1'b0) rd_low++;
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL wait ph%0d: got %h expected %h", i, trace[i], e); end
        end
        n_checks++;
        if (rd_low !== 5) begin n_fail++; $display("FAIL wait_rd_len: got %0d expected 5", rd_low); end
        n_checks++;
        if (t4_rdata !== 16'hC0DE) begin n_fail++; $display("FAIL wait_data: got %h expected c0de", t4_rdata); end
    endtask

    task automatic test_back_to_back();
        txn_t a;
        txn_t b;
        obs_t e;
        a = rand_txn(); a.wr = 1'b0;
        b = rand_txn(); b.wr = 1'b1;
        @(posedge clk); #1; present(a);
        run_xfer(a, 0, 16'h0F0F, 1'b1, b, 1'b0);
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 0, a, 1'b0);
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL b2b_first ph%0d: got %h expected %h", i, trace[i], e); end
        end
        run_xfer(b, 1, 16'h0, 1'b0, b, 1'b0);
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 1, b, 1'b0);
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL b2b_second ph%0d: got %h expected %h", i, trace[i], e); end
        end
    endtask

    task automatic test_random();
        txn_t        cur;
        txn_t        nxt;
        obs_t        e;
        bit          chain;
        int          nw;
        logic [15:0] rd;
        @(posedge clk); #1;
        cur = rand_txn();
        present(cur);
        for (int k = 0; k < 30; k++) begin
            nxt   = rand_txn();
            chain = (k < 29) && 1'($urandom);
            nw    = int'($urandom_range(0, 4));
            rd    = 16'($urandom);
            run_xfer(cur, nw, rd, chain, nxt, 1'b0);
            for (int i = 0; i < trace_len; i++) begin
                e = model(i, nw, cur, 1'b0);
                n_checks++;
                if (trace[i] !== e) begin n_fail++; $display("FAIL random%0d ph%0d: got %h expected %h", k, i, trace[i], e); end
            end
            if (!cur.wr) begin
                n_checks++;
                if (t4_rdata !== rd) begin n_fail++; $display("FAIL random%0d_data: got %h expected %h", k, t4_rdata, rd); end
            end
            if (!chain) begin
                @(posedge clk); #1;
                if (k < 29) present(nxt);
                @(negedge clk);
                n_checks++;
                if (sample() !== idle_exp()) begin n_fail++; $display("FAIL random%0d_idle: got %h expected %h", k, sample(), idle_exp()); end
            end
            cur = nxt;
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        t = rand_txn();
        t.wr = 1'b0;
        @(posedge clk); #1; present(t);
        for (int ph = 0; ph < 5; ph++) begin
            @(posedge clk); #1;
            if (ph == 0) req_valid = 1'b0;
            if (ph >= 2) ready = 1'b0;
            ad_in = 16'($urandom);
        end
        @(negedge clk);
        n_checks++;
        if (rd_n !== 1'b0) begin n_fail++; $display("FAIL reset_mid_setup: rd_n %b expected 0", rd_n); end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (sample() !== idle_exp()) begin n_fail++; $display("FAIL reset_mid_async: got %h expected %h", sample(), idle_exp()); end
        n_checks++;
        if (ad_out !== 16'h0 || rsp_rdata !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid_data: ad_out %h rsp_rdata %h, expected 0000 0000", ad_out, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (sample() !== idle_exp()) begin n_fail++; $display("FAIL reset_mid_after%0d: got %h expected %h", i, sample(), idle_exp()); end
        end
    endtask

    task automatic test_hold();
        txn_t a;
        txn_t b;
        obs_t e;
        a = rand_txn(); a.wr = 1'b0;
        b = rand_txn();
        @(posedge clk); #1; present(a);
        run_xfer(a, 1, 16'hA5A5, 1'b0, a, 1'b1);
        for (int i = 0; i < trace_len; i++) begin
            e = model(i, 1, a, 1'b1);
            n_checks++;
            if (trace[i] !== e) begin n_fail++; $display("FAIL hold_read ph%0d: got %h expected %h", i, trace[i], e); end
        end
        n_checks++;
        if (t4_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL hold_read_data: got %h expected a5a5", t4_rdata); end
        if (HOLD_EN) begin
            @(posedge clk); #1; present(b);
            @(negedge clk);
            n_checks++;
            if ({hlda, bus_oe, ad_oe, req_ready, ale} !== 5'b10000) begin
                n_fail++; $display("FAIL hold_enter: hlda/bus_oe/ad_oe/req_ready/ale %b expected 10000", {hlda, bus_oe, ad_oe, req_ready, ale});
            end
            @(posedge clk); #1; hold = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({hlda, bus_oe, req_ready} !== 3'b100) begin
                n_fail++; $display("FAIL hold_stay: hlda/bus_oe/req_ready %b expected 100", {hlda, bus_oe, req_ready});
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (sample() !== idle_exp()) begin n_fail++; $display("FAIL hold_release: got %h expected %h", sample(), idle_exp()); end
            run_xfer(b, 0, 16'h3C3C, 1'b0, b, 1'b0);
            for (int i = 0; i < trace_len; i++) begin
                e = model(i, 0, b, 1'b0);
                n_checks++;
                if (trace[i] !== e) begin n_fail++; $display("FAIL hold_pending ph%0d: got %h expected %h", i, trace[i], e); end
            end
        end else begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (sample() !== idle_exp()) begin n_fail++; $display("FAIL hold_ignored: got %h expected %h", sample(), idle_exp()); end
            hold = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_states();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_hold();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
